credit_rx_buffer: RTL and testbench
===================================

CREDIT_RX_BUFFER -- requirements
Module: credit_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning buffer slots and initial credits; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter DATA_W, default 16, meaning flit width.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_data, input, DATA_W bits: flit from upstream link.
REQ-006 SHALL have port in_valid, input, 1 bit: flit present this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: buffer not full; advisory only, since upstream is governed by credits.
REQ-008 SHALL have port out_data, output, DATA_W bits: head flit.
REQ-009 SHALL have port out_valid, output, 1 bit: buffer non-empty.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts head.
REQ-011 SHALL have port credit_out, output, 1 bit: one-cycle credit pulse to upstream; one pulse equals one slot.
REQ-012 SHALL have port init_done, output, 1 bit: all DEPTH initial credits issued.
REQ-013 SHALL have port occupancy, output, clog2(DEPTH+1) bits: stored flit count.
REQ-014 SHALL have port overflow_err, output, 1 bit: sticky flag set on a dropped flit.

Function
REQ-015 SHALL operate as a first-word-fall-through FIFO with combinational out_data = mem[rd_ptr] and out_valid = (occupancy != 0).
REQ-016 SHALL define push = in_valid and pop = out_valid && out_ready.
REQ-017 SHALL, for a push in cycle N into a non-full or simultaneously popping buffer, write the flit at the edge ending cycle N and present it at the head no earlier than cycle N+1; latency to an empty head is 1 cycle.
REQ-018 SHALL drive in_ready = (occupancy != DEPTH), which is combinational.
REQ-019 SHALL, on a push at full with no pop, drop the flit, leave the pointers and occupancy unchanged, and set overflow_err.
REQ-020 SHALL, on simultaneous push and pop at full, accept both; occupancy stays DEPTH.
REQ-021 SHALL, on simultaneous push and pop when empty, ignore the pop, since out_valid=0; the push is stored.
REQ-022 SHALL ignore out_ready while empty; there is no pointer movement and no credit.
REQ-023 SHALL wrap rd_ptr and wr_ptr modulo DEPTH and keep occupancy as a separate counter of 0..DEPTH.
REQ-024 SHALL keep credits_owed, width clog2(DEPTH+1), updated each edge as credits_owed + pop - (credits_owed != 0).
REQ-025 SHALL register credit_out each edge as (credits_owed != 0), giving at most one pulse per cycle.
REQ-026 SHALL, for a pop in cycle N with zero backlog, assert credit_out in cycle N+2.
REQ-027 SHALL queue credits without loss when pops arrive while credit_out is busy; credits_owed never exceeds DEPTH.
REQ-028 SHALL implement a two-state FSM: INIT→RUN when credits_owed reaches 0 for the first time after reset; RUN is terminal until reset.
REQ-029 SHALL drive init_done=1 in RUN.
REQ-030 SHALL accept and pop flits normally during INIT.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear rd_ptr, wr_ptr, occupancy, credit_out, overflow_err and init_done, set credits_owed=DEPTH, and set FSM=INIT.
REQ-032 SHALL not reset the memory array; out_data is don't-care while out_valid=0.
REQ-033 SHALL, on reset mid-operation, discard all stored flits, and SHALL re-issue the DEPTH initial credits after release, first credit_out in cycle 1 after the first edge.
REQ-034 SHALL clear overflow_err only by reset.

Structure
REQ-035 SHALL take the flit width default and the credit-pulse semantics constant from npu_definitions.vh; no new package types are needed.
REQ-036 SHALL use one sub-module, credit_counter, holding credits_owed, credit_out and the INIT/RUN FSM; the storage and pointers are inline.
REQ-037 SHALL be a natural downstream partner of the link credit-flow stage: credit_out connects to its credit_available, and its data_out/valid_out connect to in_data/in_valid.

Verification
REQ-038 SHALL verify reset release with no traffic -> credit_out high for exactly 8 consecutive cycles, init_done rises on the cycle after the last pulse, occupancy=0.
REQ-039 SHALL verify pushing 0x0001..0x0008 with out_ready=0 -> occupancy=8, in_ready=0, head=0x0001, overflow_err=0.
REQ-040 SHALL verify, with a full buffer, pushing 0xDEAD with out_ready=0 -> flit dropped, overflow_err=1 sticky, and the popped sequence stays 0x0001..0x0008.
REQ-041 SHALL verify, with a full buffer, simultaneous push 0x0009 and pop -> occupancy stays 8, 0x0001 delivered, 0x0009 later delivered in order.
REQ-042 SHALL verify 3 pops in consecutive cycles N..N+2 -> credit_out high in cycles N+2..N+4, with total pulses equal to pops.
REQ-043 SHALL verify rst_n low with occupancy=5 -> out_valid=0 immediately, and after release 8 fresh credits with no stale flits delivered.

Source files
------------

// File: rtl/credit_rx_buffer_pkg.sv
// credit_rx_buffer_pkg: shared constants for the credit-returning receive buffer
package credit_rx_buffer_pkg;
  localparam int DEFAULT_DATA_W = 16;
  localparam int CREDIT_SLOTS_PER_PULSE = 1;
endpackage

// File: rtl/credit_rx_buffer_credit_counter.sv
// credit_counter: owed-credit backlog, one-per-cycle credit pulse and INIT/RUN tracking
module credit_counter
  import credit_rx_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pop,
  output logic credit_out,
  output logic init_done
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  logic [CW-1:0] owed, owed_nx;
  state_e state, state_nx;
  // Each pop adds one owed credit; each cycle with a backlog pays one back
  always_comb begin
    owed_nx  = owed + CW'(pop) - ((owed != '0) ? CW'(CREDIT_SLOTS_PER_PULSE) : '0);
    state_nx = (state == ST_INIT && owed == '0) ? ST_RUN : state;
  end
  // Reset owes the full initial credit grant; RUN is held until the next reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owed       <= CW'(DEPTH);
      credit_out <= 1'b0;
      state      <= ST_INIT;
    end else begin
      owed       <= owed_nx;
      credit_out <= owed != '0;
      state      <= state_nx;
    end
  assign init_done = state == ST_RUN;
endmodule

// File: rtl/credit_rx_buffer.sv
// credit_rx_buffer: first-word-fall-through receive buffer returning one credit per consumed flit
module credit_rx_buffer
  import credit_rx_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       credit_out,
  output logic                       init_done,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic full, pop, wr_en, drop;
  // A push is stored unless the buffer is full and no pop frees a slot this edge
  always_comb begin
    full  = occupancy == OW'(DEPTH);
    pop   = out_valid && out_ready;
    wr_en = in_valid && (!full || pop);
    drop  = in_valid && full && !pop;
  end
  assign in_ready  = !full;
  assign out_valid = occupancy != '0;
  assign out_data  = mem[rd_ptr];
  // Pointers wrap naturally at the power-of-two depth; occupancy disambiguates full/empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occupancy    <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occupancy <= occupancy + OW'(wr_en) - OW'(pop);
      if (drop) overflow_err <= 1'b1;
    end
  // Storage is left unreset; out_data is only meaningful while out_valid
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= in_data;
  credit_counter #(.DEPTH(DEPTH)) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .pop        (pop),
    .credit_out (credit_out),
    .init_done  (init_done)
  );
endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb_credit_rx_buffer: directed self-checking bench for credit_rx_buffer
module tb_credit_rx_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        credit_out;
  logic        init_done;
  logic [3:0]  occupancy;
  logic        overflow_err;
  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  credit_rx_buffer #(.DEPTH(8), .DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .credit_out   (credit_out),
    .init_done    (init_done),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Credits returned for consumed flits, i.e. those after the initial grant
  always @(posedge clk)
    if (rst_n && credit_out && init_done) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_seq(input string tag);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("%s_credit_c%0d", tag, i), 32'(credit_out), 32'(i <= 8));
      chk($sformatf("%s_init_c%0d", tag, i), 32'(init_done), 32'(i >= 9));
    end
    chk({tag, "_occ"}, 32'(occupancy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_credit", 32'(credit_out), 0);
    chk("rst_init", 32'(init_done), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    chk("rst_iready", 32'(in_ready), 1);
    rst_n = 1'b1;
    init_seq("init");
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data = 16'(k);
      tick();
      if (k == 1) chk("first_head", 32'(out_data), 32'h1);
    end
    in_valid = 1'b0;
    chk("full_occ", 32'(occupancy), 8);
    chk("full_iready", 32'(in_ready), 0);
    chk("full_head", 32'(out_data), 32'h1);
    chk("full_ovf", 32'(overflow_err), 0);
    in_valid = 1'b1;
    in_data = 16'hDEAD;
    tick();
    in_valid = 1'b0;
    chk("drop_ovf", 32'(overflow_err), 1);
    chk("drop_occ", 32'(occupancy), 8);
    chk("drop_head", 32'(out_data), 32'h1);
    tick();
    chk("ovf_sticky", 32'(overflow_err), 1);
    in_valid = 1'b1;
    in_data = 16'h0009;
    out_ready = 1'b1;
    chk("pp_head", 32'(out_data), 32'h1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pp_occ", 32'(occupancy), 8);
    chk("pp_next", 32'(out_data), 32'h2);
    chk("pp_credit_n1", 32'(credit_out), 0);
    tick();
    chk("pp_credit_n2", 32'(credit_out), 1);
    tick();
    chk("pp_credit_n3", 32'(credit_out), 0);
    out_ready = 1'b1;
    chk("p3_d0", 32'(out_data), 32'h2);
    tick();
    chk("p3_d1", 32'(out_data), 32'h3);
    chk("p3_cr_n1", 32'(credit_out), 0);
    tick();
    chk("p3_d2", 32'(out_data), 32'h4);
    chk("p3_cr_n2", 32'(credit_out), 1);
    tick();
    out_ready = 1'b0;
    chk("p3_cr_n3", 32'(credit_out), 1);
    chk("p3_occ", 32'(occupancy), 5);
    tick();
    chk("p3_cr_n4", 32'(credit_out), 1);
    tick();
    chk("p3_cr_n5", 32'(credit_out), 0);
    out_ready = 1'b1;
    for (int k = 5; k <= 9; k++) begin
      chk($sformatf("drain_%0d", k), 32'(out_data), 32'(k));
      tick();
    end
    chk("drain_ovalid", 32'(out_valid), 0);
    repeat (2) tick();
    out_ready = 1'b0;
    chk("empty_pop_occ", 32'(occupancy), 0);
    repeat (12) tick();
    chk("pulse_total", 32'(pulses), 9);
    chk("quiet_credit", 32'(credit_out), 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data = 16'(16'h10 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", 32'(out_valid), 0);
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_ovf", 32'(overflow_err), 0);
    chk("mid_rst_init", 32'(init_done), 0);
    tick();
    rst_n = 1'b1;
    init_seq("reinit");
    chk("reinit_ovalid", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_data = 16'h00AA;
    tick();
    in_valid = 1'b0;
    chk("fresh_head", 32'(out_data), 32'hAA);
    chk("fresh_occ", 32'(occupancy), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fresh_empty", 32'(out_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
